// File: rtl/ibexc_data_tag_bridge.sv
// ibexc_data_tag_bridge
//
// Sits between the Ibex data port and a plain 32-bit bus and adds a 1-bit
// capability tag for every 8-byte granule of a tagged memory region. Requests
// pass straight through to the bus with no added latency. Each granted request
// is recorded in a small in-order FIFO. When its response comes back, the
// recorded entry decides the outcome:
//   - capability loads get the stored tag attached as bit 32 of the read data;
//   - writes update the tag (cap stores write the tag bit, ordinary stores
//     clear it).
//
// Ports
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   core_req_i/gnt_o     core request handshake (gated while the FIFO is full)
//   core_we_i/be_i       write enable / byte enables
//   core_addr_i          byte address
//   core_wdata_i         {tag, data} write data
//   core_is_cap_i        access is a capability access
//   core_rvalid_o        response valid (same cycle as bus_rvalid_i)
//   core_rdata_o         {tag, data} read data
//   core_err_o           response error
//   bus_*                pass-through to the untagged memory bus
//   protocol_err_o       sticky flag, set by a response with nothing outstanding

module ibexc_data_tag_bridge #(
    parameter logic [31:0] TagBase        = 32'h2001_0000,
    parameter int          NumGranules    = 2048,
    parameter int          MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        core_req_i,
    output logic        core_gnt_o,
    output logic        core_rvalid_o,
    input  logic        core_we_i,
    input  logic [3:0]  core_be_i,
    input  logic [31:0] core_addr_i,
    input  logic [32:0] core_wdata_i,
    input  logic        core_is_cap_i,
    output logic [32:0] core_rdata_o,
    output logic        core_err_o,

    output logic        bus_req_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    output logic        bus_we_o,
    output logic [3:0]  bus_be_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_err_i,

    output logic        protocol_err_o
);

    localparam int IdxW = $clog2(NumGranules);
    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [32:0] RegionBytes = 33'(NumGranules) * 33'd8;

    typedef struct packed {
        logic            we;
        logic            is_cap;
        logic            in_region;
        logic [IdxW-1:0] idx;
        logic            wtag;
    } entry_t;

    entry_t            fifo_q [MaxOutstanding];
    logic [PtrW-1:0]   rd_ptr_q;
    logic [PtrW-1:0]   wr_ptr_q;
    logic [CntW-1:0]   count_q;
    logic [NumGranules-1:0] tags_q;
    logic              protocol_err_q;

    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic [31:0] offset;
    logic        in_region;
    entry_t      new_entry;
    entry_t      head;
    logic        head_tag;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy is registered only: a response popping this cycle does not
    // free a slot until the next cycle, keeping req/gnt off the response path.
    assign full  = (count_q == CntW'(MaxOutstanding));
    assign empty = (count_q == '0);

    assign bus_req_o   = core_req_i & ~full;
    assign core_gnt_o  = bus_gnt_i & ~full;
    assign bus_we_o    = core_we_i;
    assign bus_be_o    = core_be_i;
    assign bus_addr_o  = core_addr_i;
    assign bus_wdata_o = core_wdata_i[31:0];

    // Unsigned wrap makes addresses below TagBase land far out of range.
    assign offset    = core_addr_i - TagBase;
    assign in_region = ({1'b0, offset} < RegionBytes);

    always_comb begin
        new_entry           = '0;
        new_entry.we        = core_we_i;
        new_entry.is_cap    = core_is_cap_i;
        new_entry.in_region = in_region;
        new_entry.idx       = offset[IdxW+2:3];
        new_entry.wtag      = core_wdata_i[32];
    end

    assign push     = core_gnt_o;
    assign pop      = bus_rvalid_i & ~empty;
    assign head     = fifo_q[rd_ptr_q];
    assign head_tag = tags_q[head.idx];

    assign core_rvalid_o     = pop;
    assign core_err_o        = pop & bus_err_i;
    assign core_rdata_o[31:0] = rst_ni ? bus_rdata_i : 32'h0;
    assign core_rdata_o[32]  = pop & ~head.we & head.is_cap & head.in_region
                               & ~bus_err_i & head_tag;
    assign protocol_err_o    = protocol_err_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= new_entry;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            tags_q         <= '0;
            protocol_err_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= ptr_next(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_next(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase

            // Tag write happens at the response edge, so any later response
            // (including one granted in this same cycle) sees the new value.
            if (pop && head.we && head.in_region && !bus_err_i) begin
                tags_q[head.idx] <= head.is_cap ? head.wtag : 1'b0;
            end

            if (bus_rvalid_i && empty) begin
                protocol_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ibexc_data_tag_bridge.sv
module tb_ibexc_data_tag_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        core_req_i;
    logic        core_gnt_o;
    logic        core_rvalid_o;
    logic        core_we_i;
    logic [3:0]  core_be_i;
    logic [31:0] core_addr_i;
    logic [32:0] core_wdata_i;
    logic        core_is_cap_i;
    logic [32:0] core_rdata_o;
    logic        core_err_o;
    logic        bus_req_o;
    logic        bus_gnt_i;
    logic        bus_rvalid_i;
    logic        bus_we_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_err_i;
    logic        protocol_err_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    ibexc_data_tag_bridge dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .core_req_i     (core_req_i),
        .core_gnt_o     (core_gnt_o),
        .core_rvalid_o  (core_rvalid_o),
        .core_we_i      (core_we_i),
        .core_be_i      (core_be_i),
        .core_addr_i    (core_addr_i),
        .core_wdata_i   (core_wdata_i),
        .core_is_cap_i  (core_is_cap_i),
        .core_rdata_o   (core_rdata_o),
        .core_err_o     (core_err_o),
        .bus_req_o      (bus_req_o),
        .bus_gnt_i      (bus_gnt_i),
        .bus_rvalid_i   (bus_rvalid_i),
        .bus_we_o       (bus_we_o),
        .bus_be_o       (bus_be_o),
        .bus_addr_o     (bus_addr_o),
        .bus_wdata_o    (bus_wdata_o),
        .bus_rdata_i    (bus_rdata_i),
        .bus_err_i      (bus_err_i),
        .protocol_err_o (protocol_err_o)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    task automatic idle_inputs();
        core_req_i    = 1'b0;
        core_we_i     = 1'b0;
        core_be_i     = 4'h0;
        core_addr_i   = 32'h0;
        core_wdata_i  = 33'h0;
        core_is_cap_i = 1'b0;
        bus_gnt_i     = 1'b0;
        bus_rvalid_i  = 1'b0;
        bus_rdata_i   = 32'h0;
        bus_err_i     = 1'b0;
    endtask

    // Issue one request that the bus grants immediately.
    task automatic req(input string tag, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [32:0] wdata, input logic cap);
        core_req_i    = 1'b1;
        core_we_i     = we;
        core_be_i     = be;
        core_addr_i   = addr;
        core_wdata_i  = wdata;
        core_is_cap_i = cap;
        bus_gnt_i     = 1'b1;
        #1;
        check({tag, "_gnt"}, 64'(core_gnt_o), 64'd1);
        @(posedge clk_i); #1;
        core_req_i = 1'b0;
        bus_gnt_i  = 1'b0;
    endtask

    // Deliver one bus response and check what the core sees.
    task automatic rsp(input string tag, input logic [31:0] rd, input logic err,
                       input logic [32:0] exp_rdata);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = rd;
        bus_err_i    = err;
        #1;
        check({tag, "_rvalid"}, 64'(core_rvalid_o), 64'd1);
        check({tag, "_rdata"},  64'(core_rdata_o),  64'(exp_rdata));
        check({tag, "_err"},    64'(core_err_o),    64'(err));
        @(posedge clk_i); #1;
        bus_rvalid_i = 1'b0;
        bus_err_i    = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        core_req_i   = 1'b1;
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hCAFE_F00D;
        #3;
        check("rst_bus_req",   64'(bus_req_o),      64'd1);
        check("rst_rvalid",    64'(core_rvalid_o),  64'd0);
        check("rst_rdata",     64'(core_rdata_o),   64'd0);
        check("rst_err",       64'(core_err_o),     64'd0);
        check("rst_proto",     64'(protocol_err_o), 64'd0);
        @(posedge clk_i); @(posedge clk_i); #1;
        idle_inputs();
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        // Cap store sets tag[2], cap load in the same granule sees it.
        core_req_i = 1'b1; core_we_i = 1'b1; core_addr_i = 32'h2001_0010;
        core_wdata_i = 33'h1_DEAD_BEEF; bus_gnt_i = 1'b1; core_be_i = 4'hF;
        #1;
        check("pass_wdata", 64'(bus_wdata_o), 64'hDEAD_BEEF);
        check("pass_addr",  64'(bus_addr_o),  64'h2001_0010);
        check("pass_we_be", 64'({bus_we_o, bus_be_o}), 64'h1F);
        idle_inputs();
        req("cst", 1'b1, 4'hF, 32'h2001_0010, 33'h1_DEAD_BEEF, 1'b1);
        rsp("cst", 32'h0, 1'b0, 33'h0_0000_0000);
        req("cld", 1'b0, 4'hF, 32'h2001_0014, 33'h0, 1'b1);
        rsp("cld", 32'h1234_5678, 1'b0, 33'h1_1234_5678);

        // Non-cap load never exposes the tag.
        req("nld", 1'b0, 4'hF, 32'h2001_0010, 33'h0, 1'b0);
        rsp("nld", 32'hAAAA_5555, 1'b0, 33'h0_AAAA_5555);

        // Byte store clears the tag even though wdata[32] is 1.
        req("bst", 1'b1, 4'b0001, 32'h2001_0012, 33'h1_0000_00AA, 1'b0);
        rsp("bst", 32'h0, 1'b0, 33'h0);
        req("cld2", 1'b0, 4'hF, 32'h2001_0012, 33'h0, 1'b1);
        rsp("cld2", 32'h0BAD_CAFE, 1'b0, 33'h0_0BAD_CAFE);

        // Re-tag granule 2, then errored cap store (wtag=0) must not clear it.
        req("cst2", 1'b1, 4'hF, 32'h2001_0010, 33'h1_0000_0001, 1'b1);
        rsp("cst2", 32'h0, 1'b0, 33'h0);
        req("est", 1'b1, 4'hF, 32'h2001_0010, 33'h0_0000_0000, 1'b1);
        rsp("est", 32'h0, 1'b1, 33'h0);
        req("cld3", 1'b0, 4'hF, 32'h2001_0010, 33'h0, 1'b1);
        rsp("cld3", 32'h1111_2222, 1'b0, 33'h1_1111_2222);
        // Errored cap load hides the tag.
        req("eld", 1'b0, 4'hF, 32'h2001_0010, 33'h0, 1'b1);
        rsp("eld", 32'h3333_4444, 1'b1, 33'h0_3333_4444);
        // Out-of-region cap load.
        req("old", 1'b0, 4'hF, 32'h1000_0000, 33'h0, 1'b1);
        rsp("old", 32'h5555_6666, 1'b0, 33'h0_5555_6666);

        // Region boundaries: last granule is tagged, first byte past the end is not.
        req("lst", 1'b1, 4'hF, 32'h2001_3FF8, 33'h1_0000_0000, 1'b1);
        rsp("lst", 32'h0, 1'b0, 33'h0);
        req("lld", 1'b0, 4'hF, 32'h2001_3FFC, 33'h0, 1'b1);
        rsp("lld", 32'h7777_0000, 1'b0, 33'h1_7777_0000);
        req("xst", 1'b1, 4'hF, 32'h2001_4000, 33'h1_0000_0000, 1'b1);
        rsp("xst", 32'h0, 1'b0, 33'h0);
        req("xld", 1'b0, 4'hF, 32'h2001_4000, 33'h0, 1'b1);
        rsp("xld", 32'h8888_0000, 1'b0, 33'h0_8888_0000);
        // Out-of-region store aliasing granule 0 must not tag it.
        req("g0ld", 1'b0, 4'hF, 32'h2001_0000, 33'h0, 1'b1);
        rsp("g0ld", 32'h0, 1'b0, 33'h0);

        // Full FIFO gates request and grant, including the pop cycle.
        req("f1", 1'b0, 4'hF, 32'h0000_1000, 33'h0, 1'b0);
        req("f2", 1'b0, 4'hF, 32'h0000_2000, 33'h0, 1'b0);
        core_req_i = 1'b1; bus_gnt_i = 1'b1; core_addr_i = 32'h0000_3000;
        #1;
        check("full_bus_req", 64'(bus_req_o),  64'd0);
        check("full_gnt",     64'(core_gnt_o), 64'd0);
        @(posedge clk_i); #1;
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0000_0F01;
        #1;
        check("pop_rvalid",   64'(core_rvalid_o), 64'd1);
        check("pop_bus_req",  64'(bus_req_o),     64'd0);
        check("pop_gnt",      64'(core_gnt_o),    64'd0);
        @(posedge clk_i); #1;
        bus_rvalid_i = 1'b0;
        #1;
        check("after_pop_req", 64'(bus_req_o),  64'd1);
        check("after_pop_gnt", 64'(core_gnt_o), 64'd1);
        @(posedge clk_i); #1;
        idle_inputs();
        rsp("f2", 32'h0000_0F02, 1'b0, 33'h0_0000_0F02);
        rsp("f3", 32'h0000_0F03, 1'b0, 33'h0_0000_0F03);

        // Store response and load grant in the same cycle (granule 5).
        req("hst", 1'b1, 4'hF, 32'h2001_0028, 33'h1_0000_0000, 1'b1);
        core_req_i = 1'b1; bus_gnt_i = 1'b1; core_we_i = 1'b0; core_is_cap_i = 1'b1;
        core_addr_i = 32'h2001_002C; bus_rvalid_i = 1'b1; bus_rdata_i = 32'h0;
        #1;
        check("hz_gnt",    64'(core_gnt_o),    64'd1);
        check("hz_rvalid", 64'(core_rvalid_o), 64'd1);
        @(posedge clk_i); #1;
        idle_inputs();
        rsp("hld", 32'h9999_AAAA, 1'b0, 33'h1_9999_AAAA);
        check("proto_clean", 64'(protocol_err_o), 64'd0);

        // Stray response: dropped and sticky error.
        bus_rvalid_i = 1'b1; bus_rdata_i = 32'hFFFF_0000;
        #1;
        check("stray_rvalid", 64'(core_rvalid_o), 64'd0);
        @(posedge clk_i); #1;
        bus_rvalid_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("proto_sticky", 64'(protocol_err_o), 64'd1);
        rst_ni = 1'b0;
        #1;
        check("proto_rst", 64'(protocol_err_o), 64'd0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        // Tags cleared by reset.
        req("rld", 1'b0, 4'hF, 32'h2001_0010, 33'h0, 1'b1);
        rsp("rld", 32'h0, 1'b0, 33'h0);

        // Reset with a request outstanding discards it.
        req("mid", 1'b0, 4'hF, 32'h2001_0010, 33'h0, 1'b0);
        rst_ni = 1'b0;
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        bus_rvalid_i = 1'b1;
        #1;
        check("mid_rvalid", 64'(core_rvalid_o), 64'd0);
        @(posedge clk_i); #1;
        bus_rvalid_i = 1'b0;
        check("mid_proto", 64'(protocol_err_o), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
